// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: word/data widths, RAM command opcodes, FSM states.
package spi_pkg;

    localparam int WORD_W = 10;
    localparam int DATA_W = 8;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// SPI pins plus the RAM-side command/read-data bus of the SPI slave controller.
interface spi_slave_ctrl_if;
    import spi_pkg::*;

    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [WORD_W-1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );

endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave to RAM command bridge; rx_valid pulses the cycle after the 10th word bit, MISO starts the cycle after tx_data capture.
// No backpressure: the read byte waits on tx_valid, and SS_n high aborts a frame at the next edge.
module spi_slave_ctrl
    import spi_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    spi_slave_ctrl_if.slave bus
);

    state_t            state;
    logic [3:0]        bit_cnt;
    logic [WORD_W-2:0] shift_reg;
    logic              word_done;
    logic [DATA_W-2:0] tx_shift;
    logic [2:0]        tx_cnt;
    logic              tx_busy;
    logic              tx_done;
    logic              rd_addr_done;

    logic in_word_state;
    logic word_end;
    logic tx_start;

    assign in_word_state = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    // A word completes only while SS_n is still low on the sampling edge of its 10th bit.
    assign word_end = !bus.SS_n && in_word_state && !word_done && (bit_cnt == 4'(WORD_W - 1));
    assign tx_start = !bus.SS_n && (state == READ_DATA) && word_done && !tx_busy && !tx_done
                      && bus.tx_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (bus.SS_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= CHK_CMD;
                CHK_CMD: state <= bus.MOSI ? (rd_addr_done ? READ_DATA : READ_ADD) : WRITE;
                default: state <= state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            word_done <= 1'b0;
        end else if (bus.SS_n || !in_word_state) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            word_done <= 1'b0;
        end else if (!word_done) begin
            if (bit_cnt == 4'(WORD_W - 1)) begin
                bit_cnt   <= '0;
                word_done <= 1'b1;
            end else begin
                shift_reg <= {shift_reg[WORD_W-3:0], bus.MOSI};
                bit_cnt   <= bit_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
            bus.MISO     <= 1'b0;
            rd_addr_done <= 1'b0;
            tx_shift     <= '0;
            tx_cnt       <= '0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            if (word_end) begin
                bus.rx_data  <= {shift_reg, bus.MOSI};
                bus.rx_valid <= 1'b1;
                if (state == READ_ADD)
                    rd_addr_done <= 1'b1;
            end

            if (bus.SS_n) begin
                bus.MISO <= 1'b0;
                tx_cnt   <= '0;
                tx_busy  <= 1'b0;
                tx_done  <= 1'b0;
            end else if (tx_start) begin
                bus.MISO <= bus.tx_data[DATA_W-1];
                tx_shift <= bus.tx_data[DATA_W-2:0];
                tx_cnt   <= 3'(DATA_W - 1);
                tx_busy  <= 1'b1;
            end else if (tx_busy) begin
                if (tx_cnt != 3'd0) begin
                    bus.MISO <= tx_shift[DATA_W-2];
                    tx_shift <= {tx_shift[DATA_W-3:0], 1'b0};
                    tx_cnt   <= tx_cnt - 3'd1;
                end else begin
                    // Byte fully out: the read address is consumed, frame stays dead until SS_n rises.
                    bus.MISO     <= 1'b0;
                    tx_busy      <= 1'b0;
                    tx_done      <= 1'b1;
                    rd_addr_done <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: a scoreboard checks every rx_data strobe, a small RAM model
// answers read commands, and the stimulus checks MISO, state and rd_addr_done at key points.
module tb_spi_slave_ctrl;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    spi_slave_ctrl_if bus();

    spi_slave_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int unsigned last_vld_cyc = 0;
    int unsigned t0 = 0;
    logic [9:0]  exp_q[$];
    logic        prev_vld = 1'b0;

    logic [7:0]  mem [256];
    logic [7:0]  wr_addr = 8'h00;
    logic [7:0]  rd_addr = 8'h00;
    int          tx_dly = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every rx_valid must match the next queued word and last one cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.rx_valid) begin
                last_vld_cyc = cyc;
                check("rx_word_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0)
                    check("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
                check("rx_valid_pulse", 32'(prev_vld), 32'd0);
            end
            prev_vld = bus.rx_valid;
        end
    end

    // RAM model: decodes strobed commands, answers a read three cycles later, tx_valid sticky until reset.
    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (!rst_n) begin
                bus.tx_valid = 1'b0;
                tx_dly = 0;
            end else begin
                if (tx_dly != 0) begin
                    tx_dly--;
                    if (tx_dly == 0) begin
                        bus.tx_data  = mem[rd_addr];
                        bus.tx_valid = 1'b1;
                    end
                end
                if (bus.rx_valid) begin
                    case (bus.rx_data[9:8])
                        WR_ADDR: wr_addr = bus.rx_data[7:0];
                        WR_DATA: mem[wr_addr] = bus.rx_data[7:0];
                        RD_ADDR: rd_addr = bus.rx_data[7:0];
                        RD_DATA: tx_dly = 3;
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic start_frame(input logic cmd);
        @(negedge clk);
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        @(negedge clk);
        bus.MOSI = cmd;
    endtask

    task automatic shift_word(input logic [9:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.MOSI = w[9-i];
        end
    endtask

    task automatic end_frame(input string name);
        @(negedge clk);
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        @(negedge clk);
        check(name, 32'(dut.state), 32'(IDLE));
    endtask

    // Returns on the negedge where the word's rx_valid is visible.
    task automatic full_frame(input logic cmd, input logic [9:0] w);
        exp_q.push_back(w);
        start_frame(cmd);
        shift_word(w, 10);
        @(negedge clk);
    endtask

    task automatic read_out(input logic [7:0] b);
        int n;
        n = 0;
        while (!bus.tx_valid && n < 20) begin
            check("miso_idle_wait", 32'(bus.MISO), 32'd0);
            @(negedge clk);
            n++;
        end
        check("tx_valid_seen", 32'(bus.tx_valid), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("miso_bit", 32'(bus.MISO), 32'(b[7-i]));
        end
        @(negedge clk);
        check("miso_after_byte", 32'(bus.MISO), 32'd0);
        check("rd_addr_done_clear", 32'(dut.rd_addr_done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(bus.MISO), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_rd_addr_done", 32'(dut.rd_addr_done), 32'd0);

        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_until_ss", 32'(dut.state), 32'(IDLE));

        // Write address 5, then stray bits in the same frame must be ignored.
        exp_q.push_back(10'h005);
        start_frame(1'b0);
        t0 = cyc;
        check("chk_cmd_state", 32'(dut.state), 32'(CHK_CMD));
        shift_word(10'h005, 10);
        @(negedge clk);
        @(negedge clk);
        check("wr_addr_latency", 32'(last_vld_cyc - t0), 32'd11);
        check("rx_data_hold", 32'(bus.rx_data), 32'h005);
        shift_word(10'h3FF, 5);
        end_frame("idle_after_wr_addr");

        full_frame(1'b0, 10'h1AA);
        end_frame("idle_after_wr_data");
        check("ram_addr5", 32'(mem[5]), 32'hAA);

        // Opcode is forwarded as-is even when it disagrees with the state.
        full_frame(1'b0, {RD_ADDR, 8'h03});
        check("wr_state_no_rd_addr_done", 32'(dut.rd_addr_done), 32'd0);
        end_frame("idle_after_passthru");

        // Abort after 6 bits.
        start_frame(1'b0);
        shift_word(10'h3FF, 6);
        end_frame("idle_after_abort");
        check("abort_rx_data_hold", 32'(bus.rx_data), 32'h203);

        // SS_n rising on the 10th-bit edge discards the read-address word.
        start_frame(1'b1);
        shift_word(10'h205, 9);
        @(negedge clk);
        bus.MOSI = 1'b1;
        bus.SS_n = 1'b1;
        @(negedge clk);
        check("late_abort_state", 32'(dut.state), 32'(IDLE));
        check("late_abort_rd_addr_done", 32'(dut.rd_addr_done), 32'd0);

        full_frame(1'b1, 10'h205);
        check("rd_addr_done_set", 32'(dut.rd_addr_done), 32'd1);
        end_frame("idle_after_rd_addr");

        full_frame(1'b1, 10'h300);
        read_out(8'hAA);
        shift_word(10'h3FF, 10);
        check("miso_after_extra_bits", 32'(bus.MISO), 32'd0);
        end_frame("idle_after_rd_data");

        // Reset while the read byte is being shifted out.
        full_frame(1'b1, 10'h205);
        end_frame("idle_after_rd_addr2");
        full_frame(1'b1, 10'h300);
        check("tx_valid_sticky", 32'(bus.tx_valid), 32'd1);
        @(negedge clk);
        check("miso_b7", 32'(bus.MISO), 32'd1);
        @(negedge clk);
        check("miso_b6", 32'(bus.MISO), 32'd0);
        @(negedge clk);
        check("miso_b5", 32'(bus.MISO), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_miso", 32'(bus.MISO), 32'd0);
        check("arst_state", 32'(dut.state), 32'(IDLE));
        check("arst_rd_addr_done", 32'(dut.rd_addr_done), 32'd0);
        check("arst_rx_valid", 32'(bus.rx_valid), 32'd0);
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        full_frame(1'b0, 10'h007);
        end_frame("idle_after_post_reset");

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_ctrl.md
SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

Interface
REQ-001 The block SHALL have no parameters; word width 10 and data width 8 SHALL come from the shared package.
REQ-002 clk  input  1  single system clock; every state change, and every MOSI sample and MISO update, occurs on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SS_n  input  1  SPI slave select, active-low; a frame lasts while it is low.
REQ-005 MOSI  input  1  serial data from the master, MSB first.
REQ-006 MISO  output  1  serial read data to the master, MSB first.
REQ-007 rx_data  output  10  command word to the RAM; [9:8] is the opcode, [7:0] is the address or data.
REQ-008 rx_valid  output  1  one-cycle strobe qualifying rx_data.
REQ-009 tx_data  input  8  read data returned by the RAM.
REQ-010 tx_valid  input  1  level qualifying tx_data; it stays high once set until RAM reset.

Function
REQ-011 FSM states SHALL be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-012 IDLE: SS_n=0 -> CHK_CMD, else stay.
REQ-013 CHK_CMD samples one MOSI bit, and that bit SHALL NOT be part of the word: 0 -> WRITE; 1 with rd_addr_done=0 -> READ_ADD; 1 with rd_addr_done=1 -> READ_DATA.
REQ-014 WRITE, READ_ADD and READ_DATA SHALL shift 10 MOSI bits, MSB first, into a shift register, counted by a 4-bit counter 0..9.
REQ-015 The cycle after the 10th bit is sampled, rx_data SHALL equal the shifted word and rx_valid SHALL be 1 for exactly one cycle.
REQ-016 rx_data SHALL hold its value until the next completed word.
REQ-017 Opcode bits are forwarded unmodified; the block SHALL NOT check the opcode against the state.
REQ-018 rd_addr_done SHALL set when a READ_ADD word completes.
REQ-019 rd_addr_done SHALL clear when a READ_DATA byte has been fully shifted out.
REQ-020 After its word is strobed, READ_DATA SHALL wait for tx_valid=1 and then capture tx_data.
REQ-021 On the 8 cycles after capture, MISO SHALL drive tx_data[7] down to tx_data[0], one bit per cycle.
REQ-022 After the 8th bit, MISO SHALL return to 0 and no further word is accepted until SS_n rises.
REQ-023 Outside the byte shift-out, MISO SHALL be 0.
REQ-024 SS_n=1 in any state SHALL force IDLE on the next edge, discard any partial word, leave rd_addr_done unchanged and emit no rx_valid.
REQ-025 If SS_n rises on the same edge that the 10th bit is sampled, the word SHALL be discarded and no rx_valid emitted.
REQ-026 Bits on MOSI after the 10th within the same frame SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL, asynchronously, set state=IDLE, the counter, shift register, rx_data, rx_valid, MISO and rd_addr_done to 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no rx_valid.
REQ-029 After reset is released, the first frame SHALL begin only when SS_n=0 is seen in IDLE.

Structure
REQ-030 Package spi_pkg SHALL hold the state enum and the constants WORD_W=10, DATA_W=8 and the opcodes WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11.
REQ-031 The block SHALL be a single module with no sub-module; the next-state, counter/shift and output logic SHALL each be a separate process.

Verification
REQ-032 Write address: SS_n low, MOSI 0 then 00_0000_0101 -> rx_data=10'h005 with a 1-cycle rx_valid, 11 cycles after CHK_CMD.
REQ-033 Write data: MOSI 0 then 01_1010_1010 -> rx_data=10'h1AA with rx_valid; after a 00/01 pair to address 5, the RAM holds 8'hAA at address 5.
REQ-034 Read address: MOSI 1 then 10_0000_0101 -> rx_data=10'h205 and rd_addr_done=1.
REQ-035 Read data: SS_n cycled, MOSI 1 then 11_xxxx_xxxx -> rx_data[9:8]=2'b11 and rx_valid; on tx_valid with tx_data=8'hAA, MISO shows 1,0,1,0,1,0,1,0 on 8 consecutive cycles, then rd_addr_done=0.
REQ-036 Abort: SS_n raised after 6 word bits -> no rx_valid, IDLE next cycle, and a following full frame decodes correctly.
REQ-037 Reset in READ_DATA mid-shift -> MISO=0, state IDLE and rd_addr_done=0 immediately, without waiting for a clock edge.
